// File: rtl/ride_dispatcher.sv
// Ride sequencer: collects origin/destination, grants a free driver round-robin,
// then walks the assigned car to the pickup point and on to the destination.
module ride_dispatcher #(
    parameter int N_LOC = 9,
    parameter int HOME0 = 0,
    parameter int HOME1 = 2,
    parameter int HOME2 = 5,
    parameter int HOME3 = 8
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iTICK,
    input  logic             iPEDIDO,
    input  logic             iCONFIRM,
    input  logic [3:0]       iSEL,
    input  logic [3:0]       iDRV_BUSY,
    output logic [2:0]       oSTATE,
    output logic [3:0]       oORIGIN,
    output logic [3:0]       oDEST,
    output logic [3:0]       oDIST,
    output logic [1:0]       oDRV_ID,
    output logic             oDRV_VALID,
    output logic [3:0]       oCAR_POS,
    output logic [N_LOC-1:0] oLEDR,
    output logic             oMODE,
    output logic             oERR,
    output logic             oDONE
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_ORIG = 3'd1;
    localparam logic [2:0] S_GET_DEST = 3'd2;
    localparam logic [2:0] S_ASSIGN   = 3'd3;
    localparam logic [2:0] S_PICKUP   = 3'd4;
    localparam logic [2:0] S_TRIP     = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam logic [3:0] LOC_LIMIT = 4'(N_LOC);
    localparam logic [N_LOC-1:0] LED_ONE = {{(N_LOC-1){1'b0}}, 1'b1};

    function automatic logic [3:0] home_of(input logic [1:0] k);
        logic [3:0] h;
        case (k)
            2'd0:    h = 4'(HOME0);
            2'd1:    h = 4'(HOME1);
            2'd2:    h = 4'(HOME2);
            2'd3:    h = 4'(HOME3);
            default: h = 4'd0;
        endcase
        return h;
    endfunction

    function automatic logic [3:0] step_toward(input logic [3:0] pos, input logic [3:0] tgt);
        return (pos < tgt) ? (pos + 4'd1) : (pos - 4'd1);
    endfunction

    logic [2:0]       state_q,     state_d;
    logic [3:0]       origin_q,    origin_d;
    logic [3:0]       dest_q,      dest_d;
    logic [3:0]       dist_q,      dist_d;
    logic [1:0]       drv_id_q,    drv_id_d;
    logic             drv_valid_q, drv_valid_d;
    logic [3:0]       car_pos_q,   car_pos_d;
    logic [N_LOC-1:0] ledr_q,      ledr_d;
    logic             mode_q,      mode_d;
    logic             err_q,       err_d;
    logic             done_q,      done_d;
    logic [1:0]       ptr_q,       ptr_d;

    logic [3:0] rot_busy_s;
    logic [1:0] grant_off_s;
    logic       grant_found_s;
    logic [1:0] grant_id_s;
    logic       clear_s;

    // Rotate busy flags so bit 0 is the driver the round-robin pointer names.
    always_comb begin
        case (ptr_q)
            2'd0:    rot_busy_s = iDRV_BUSY;
            2'd1:    rot_busy_s = {iDRV_BUSY[0],   iDRV_BUSY[3:1]};
            2'd2:    rot_busy_s = {iDRV_BUSY[1:0], iDRV_BUSY[3:2]};
            2'd3:    rot_busy_s = {iDRV_BUSY[2:0], iDRV_BUSY[3]};
            default: rot_busy_s = iDRV_BUSY;
        endcase
    end

    // First free driver at or after the pointer.
    always_comb begin
        grant_found_s = 1'b1;
        if (!rot_busy_s[0]) begin
            grant_off_s = 2'd0;
        end else if (!rot_busy_s[1]) begin
            grant_off_s = 2'd1;
        end else if (!rot_busy_s[2]) begin
            grant_off_s = 2'd2;
        end else if (!rot_busy_s[3]) begin
            grant_off_s = 2'd3;
        end else begin
            grant_off_s   = 2'd0;
            grant_found_s = 1'b0;
        end
        grant_id_s = ptr_q + grant_off_s;
    end

    // Dropping the request anywhere past IDLE cancels or releases the ride; it outranks confirm/tick.
    assign clear_s = !iPEDIDO && (state_q != S_IDLE);

    // Next-state and ride-register update.
    always_comb begin
        state_d     = state_q;
        origin_d    = origin_q;
        dest_d      = dest_q;
        dist_d      = dist_q;
        drv_id_d    = drv_id_q;
        drv_valid_d = drv_valid_q;
        car_pos_d   = car_pos_q;
        ptr_d       = ptr_q;
        err_d       = 1'b0;
        done_d      = 1'b0;
        if (clear_s) begin
            state_d     = S_IDLE;
            origin_d    = 4'd0;
            dest_d      = 4'd0;
            dist_d      = 4'd0;
            drv_id_d    = 2'd0;
            drv_valid_d = 1'b0;
            car_pos_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    origin_d = 4'd0;
                    dest_d   = 4'd0;
                    dist_d   = 4'd0;
                    if (iPEDIDO) begin
                        state_d = S_GET_ORIG;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_GET_ORIG: begin
                    if (iCONFIRM && (iSEL < LOC_LIMIT)) begin
                        origin_d = iSEL;
                        state_d  = S_GET_DEST;
                    end else if (iCONFIRM) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_GET_ORIG;
                    end
                end
                S_GET_DEST: begin
                    if (iCONFIRM && (iSEL < LOC_LIMIT) && (iSEL != origin_q)) begin
                        dest_d  = iSEL;
                        dist_d  = (iSEL > origin_q) ? (iSEL - origin_q) : (origin_q - iSEL);
                        state_d = S_ASSIGN;
                    end else if (iCONFIRM) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_GET_DEST;
                    end
                end
                S_ASSIGN: begin
                    if (grant_found_s) begin
                        drv_id_d    = grant_id_s;
                        drv_valid_d = 1'b1;
                        car_pos_d   = home_of(grant_id_s);
                        ptr_d       = grant_id_s + 2'd1;
                        state_d     = S_PICKUP;
                    end else begin
                        state_d = S_ASSIGN;
                    end
                end
                S_PICKUP: begin
                    if (iTICK && (car_pos_q == origin_q)) begin
                        state_d = S_TRIP;
                    end else if (iTICK) begin
                        car_pos_d = step_toward(car_pos_q, origin_q);
                    end else begin
                        state_d = S_PICKUP;
                    end
                end
                S_TRIP: begin
                    if (iTICK && (car_pos_q == dest_q)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (iTICK) begin
                        car_pos_d = step_toward(car_pos_q, dest_q);
                    end else begin
                        state_d = S_TRIP;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d     = S_IDLE;
                    origin_d    = 4'd0;
                    dest_d      = 4'd0;
                    dist_d      = 4'd0;
                    drv_id_d    = 2'd0;
                    drv_valid_d = 1'b0;
                    car_pos_d   = 4'd0;
                end
            endcase
        end
    end

    // Display-side outputs follow the next-state values so they stay aligned with the registers.
    always_comb begin
        if (drv_valid_d) begin
            ledr_d = LED_ONE << car_pos_d;
        end else begin
            ledr_d = '0;
        end
        mode_d = (state_d == S_PICKUP) || (state_d == S_TRIP) || (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= S_IDLE;
            origin_q    <= 4'd0;
            dest_q      <= 4'd0;
            dist_q      <= 4'd0;
            drv_id_q    <= 2'd0;
            drv_valid_q <= 1'b0;
            car_pos_q   <= 4'd0;
            ledr_q      <= '0;
            mode_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            ptr_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            origin_q    <= origin_d;
            dest_q      <= dest_d;
            dist_q      <= dist_d;
            drv_id_q    <= drv_id_d;
            drv_valid_q <= drv_valid_d;
            car_pos_q   <= car_pos_d;
            ledr_q      <= ledr_d;
            mode_q      <= mode_d;
            err_q       <= err_d;
            done_q      <= done_d;
            ptr_q       <= ptr_d;
        end
    end

    assign oSTATE     = state_q;
    assign oORIGIN    = origin_q;
    assign oDEST      = dest_q;
    assign oDIST      = dist_q;
    assign oDRV_ID    = drv_id_q;
    assign oDRV_VALID = drv_valid_q;
    assign oCAR_POS   = car_pos_q;
    assign oLEDR      = ledr_q;
    assign oMODE      = mode_q;
    assign oERR       = err_q;
    assign oDONE      = done_q;

endmodule

// File: tb/tb_ride_dispatcher.sv
// Randomized ride-level bench for ride_dispatcher; expectations come from ride
// rules (round-robin pick, step counts toward targets), not from the RTL's structure.
module tb_ride_dispatcher;

    logic       iCLK = 1'b0;
    logic       iRST_N;
    logic       iTICK;
    logic       iPEDIDO;
    logic       iCONFIRM;
    logic [3:0] iSEL;
    logic [3:0] iDRV_BUSY;
    logic [2:0] oSTATE;
    logic [3:0] oORIGIN;
    logic [3:0] oDEST;
    logic [3:0] oDIST;
    logic [1:0] oDRV_ID;
    logic       oDRV_VALID;
    logic [3:0] oCAR_POS;
    logic [8:0] oLEDR;
    logic       oMODE;
    logic       oERR;
    logic       oDONE;

    int n_pass  = 0;
    int n_total = 0;
    int m_ptr   = 0;
    int home_tab [4];

    ride_dispatcher dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iTICK(iTICK), .iPEDIDO(iPEDIDO),
        .iCONFIRM(iCONFIRM), .iSEL(iSEL), .iDRV_BUSY(iDRV_BUSY),
        .oSTATE(oSTATE), .oORIGIN(oORIGIN), .oDEST(oDEST), .oDIST(oDIST),
        .oDRV_ID(oDRV_ID), .oDRV_VALID(oDRV_VALID), .oCAR_POS(oCAR_POS),
        .oLEDR(oLEDR), .oMODE(oMODE), .oERR(oERR), .oDONE(oDONE)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge iCLK);
        #1;
    endtask

    task automatic confirm(input int sel);
        iSEL     = 4'(sel);
        iCONFIRM = 1'b1;
        iTICK    = 1'b0;
        cyc();
        iCONFIRM = 1'b0;
    endtask

    function automatic int pick(input int ptr, input logic [3:0] busy);
        for (int i = 0; i < 4; i++) begin
            if (!busy[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic check_cleared(input string tag);
        check({tag, "_state"}, int'(oSTATE), 0);
        check({tag, "_valid"}, int'(oDRV_VALID), 0);
        check({tag, "_ledr"},  int'(oLEDR), 0);
        check({tag, "_pos"},   int'(oCAR_POS), 0);
        check({tag, "_mode"},  int'(oMODE), 0);
        check({tag, "_dest"},  int'(oDEST), 0);
    endtask

    // One full ride; phase numbers are the published state codes.
    task automatic do_ride(input int org, input int dst, input logic [3:0] busy,
                           input int busy_wait, input bit bad, input int cancel_pos,
                           input bit cancel_tick, input bit rst_pickup);
        int id, pos, phase, guard, exp_done;
        bit tk;
        iPEDIDO   = 1'b1;
        iDRV_BUSY = (busy_wait > 0) ? 4'hF : busy;
        cyc();
        check("enter_orig", int'(oSTATE), 1);
        check("orig_mode", int'(oMODE), 0);
        if (bad) begin
            confirm(9);
            check("bad_orig_err", int'(oERR), 1);
            check("bad_orig_state", int'(oSTATE), 1);
            cyc();
            check("err_one_cycle", int'(oERR), 0);
        end
        confirm(org);
        check("orig_state", int'(oSTATE), 2);
        check("orig_latch", int'(oORIGIN), org);
        if (bad) begin
            confirm(org);
            check("same_dest_err", int'(oERR), 1);
            check("same_dest_state", int'(oSTATE), 2);
        end
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            iTICK = 1'($urandom % 2);
            cyc();
            iTICK = 1'b0;
            check("dest_wait", int'(oSTATE), 2);
        end
        confirm(dst);
        check("assign_state", int'(oSTATE), 3);
        check("dest_latch", int'(oDEST), dst);
        check("dist", int'(oDIST), iabs(dst - org));
        for (int w = 0; w < busy_wait; w++) begin
            cyc();
            check("all_busy_hold", int'(oSTATE), 3);
            check("all_busy_novalid", int'(oDRV_VALID), 0);
        end
        iDRV_BUSY = busy;
        id = pick(m_ptr, busy);
        cyc();
        check("grant_state", int'(oSTATE), 4);
        check("grant_id", int'(oDRV_ID), id);
        check("grant_valid", int'(oDRV_VALID), 1);
        check("grant_mode", int'(oMODE), 1);
        pos = home_tab[id];
        check("grant_home", int'(oCAR_POS), pos);
        check("grant_ledr", int'(oLEDR), 1 << pos);
        m_ptr = (id + 1) % 4;
        if (rst_pickup) begin
            iTICK = 1'b1;
            cyc();
            iTICK = 1'b0;
            if (pos != org) pos += (org > pos) ? 1 : -1;
            check("pre_reset_pos", int'(oCAR_POS), pos);
            #2;
            iRST_N = 1'b0;
            #1;
            check_cleared("async_rst");
            check("async_rst_id", int'(oDRV_ID), 0);
            check("async_rst_orig", int'(oORIGIN), 0);
            iPEDIDO = 1'b0;
            #2;
            iRST_N = 1'b1;
            m_ptr = 0;
            cyc();
            check("post_reset_state", int'(oSTATE), 0);
            return;
        end
        phase = 4;
        guard = 0;
        while (phase != 6 && guard < 100) begin
            guard++;
            tk = ($urandom % 3) != 0;
            if (phase == 5 && pos == cancel_pos) begin
                iPEDIDO = 1'b0;
                iTICK   = cancel_tick;
                cyc();
                iTICK = 1'b0;
                check_cleared("cancel");
                check("cancel_orig", int'(oORIGIN), 0);
                check("cancel_dist", int'(oDIST), 0);
                return;
            end
            iTICK    = tk;
            iCONFIRM = 1'($urandom % 2);
            iSEL     = 4'($urandom % 16);
            cyc();
            iTICK    = 1'b0;
            iCONFIRM = 1'b0;
            exp_done = 0;
            if (tk) begin
                if (phase == 4) begin
                    if (pos == org) phase = 5;
                    else pos += (org > pos) ? 1 : -1;
                end else begin
                    if (pos == dst) begin
                        phase    = 6;
                        exp_done = 1;
                    end else begin
                        pos += (dst > pos) ? 1 : -1;
                    end
                end
            end
            check("move_state", int'(oSTATE), phase);
            check("move_pos", int'(oCAR_POS), pos);
            check("move_done", int'(oDONE), exp_done);
            check("move_ledr", int'(oLEDR), 1 << pos);
            check("move_err", int'(oERR), 0);
        end
        check("ride_timeout", phase, 6);
        cyc();
        check("done_pulse_end", int'(oDONE), 0);
        check("done_hold", int'(oSTATE), 6);
        check("done_ledr", int'(oLEDR), 1 << dst);
        check("done_mode", int'(oMODE), 1);
        iPEDIDO = 1'b0;
        cyc();
        check_cleared("release");
    endtask

    initial begin
        home_tab  = '{0, 2, 5, 8};
        iRST_N    = 1'b0;
        iTICK     = 1'b0;
        iPEDIDO   = 1'b0;
        iCONFIRM  = 1'b0;
        iSEL      = 4'd0;
        iDRV_BUSY = 4'd0;
        repeat (3) @(posedge iCLK);
        #2;
        iRST_N = 1'b1;
        cyc();
        check_cleared("reset");
        check("reset_err", int'(oERR), 0);
        check("reset_done", int'(oDONE), 0);
        check("reset_dist", int'(oDIST), 0);

        iCONFIRM = 1'b1;
        iTICK    = 1'b1;
        cyc();
        iCONFIRM = 1'b0;
        iTICK    = 1'b0;
        check("idle_ignore", int'(oSTATE), 0);
        check("idle_noerr", int'(oERR), 0);

        do_ride(3, 6, 4'b0000, 0, 1'b0, -1, 1'b0, 1'b0);
        do_ride(1, 7, 4'b0000, 0, 1'b0, -1, 1'b0, 1'b0);
        do_ride(4, 2, 4'b0110, 0, 1'b0, -1, 1'b0, 1'b0);
        do_ride(6, 8, 4'b0001, 0, 1'b0, -1, 1'b0, 1'b0);
        do_ride(2, 3, 4'b1011, 4, 1'b0, -1, 1'b0, 1'b0);
        do_ride(4, 0, 4'b0000, 0, 1'b1, -1, 1'b0, 1'b0);
        do_ride(7, 1, 4'b0000, 0, 1'b0, 5, 1'b0, 1'b0);
        do_ride(3, 8, 4'b0000, 0, 1'b0, 5, 1'b1, 1'b0);
        do_ride(2, 0, 4'b0111, 0, 1'b0, -1, 1'b0, 1'b0);
        do_ride(5, 1, 4'b0000, 0, 1'b0, -1, 1'b0, 1'b0);
        do_ride(5, 1, 4'b0000, 0, 1'b0, -1, 1'b0, 1'b1);
        do_ride(1, 4, 4'b0000, 0, 1'b0, -1, 1'b0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            int o, d;
            o = int'($urandom % 9);
            d = int'($urandom % 8);
            if (d >= o) d++;
            do_ride(o, d, 4'($urandom % 15), int'($urandom % 3), 1'($urandom % 2),
                    (($urandom % 4) == 0) ? int'($urandom % 9) : -1,
                    1'($urandom % 2), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
